oc_sense: RTL and testbench



---
 rtl/oc_sense.sv | 205 ++++++++++++++++++++
 tb/tb_oc_sense.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oc_sense.sv
// Over-current sense front end: polls a 16-bit-frame serial ADC and debounces the 12-bit result against hysteresis thresholds.
// Define OC_SENSE_PEAK_EN to add the peak-hold register (peak_clr input, peak output).
module oc_sense #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_CYC  = 8,
  parameter int DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] th_high,
  input  logic [11:0] th_low,
  input  logic        adc_miso,
`ifdef OC_SENSE_PEAK_EN
  input  logic        peak_clr,
  output logic [11:0] peak,
`endif
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        over_current
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  // Phases 0..31 are the 16 low/high SCLK halves; phase 32 is the trailing high hold.
  localparam logic [5:0]       PHASE_LAST = 6'd32;
  localparam logic [3:0]       DEB_CNT    = 4'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       phase_reg, phase_next;
  logic             capture;
  logic             cs_n_next, sclk_next;
  logic             idle_clear;

  logic             cs_n_reg, sclk_reg;
  logic [11:0]      shift_reg;
  logic [11:0]      sample_reg;
  logic             sample_valid_reg;
  logic             oc_reg;
  logic [3:0]       hi_cnt_reg, lo_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      phase_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (enable) begin
          state_next = S_SETUP;
          cnt_next   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_reg == DIV_LAST) begin
          state_next = S_SHIFT;
          cnt_next   = '0;
          phase_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (phase_reg == PHASE_LAST) begin
            state_next = S_DONE;
          end else begin
            phase_next = phase_reg + 6'd1;
            // Leaving a low half means SCLK rises on this edge: take the data bit now.
            capture    = ~phase_reg[0];
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_GAP;
        cnt_next   = '0;
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = enable ? S_SETUP : S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    cs_n_next  = ~((state_next == S_SETUP) || (state_next == S_SHIFT));
    sclk_next  = ~((state_next == S_SHIFT) && (phase_next != PHASE_LAST) && ~phase_next[0]);
    idle_clear = (state_next == S_IDLE) && ~enable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_reg         <= 1'b1;
      sclk_reg         <= 1'b1;
      shift_reg        <= '0;
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      cs_n_reg         <= cs_n_next;
      sclk_reg         <= sclk_next;
      // Only 12 bits are kept; the 4 leading frame bits fall off the top.
      if (capture)
        shift_reg <= {shift_reg[10:0], adc_miso};
      sample_valid_reg <= (state_next == S_DONE);
      if (state_next == S_DONE)
        sample_reg <= shift_reg;
    end
  end

  // Debounced hysteresis detector; evaluated once per strobe using the live thresholds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_reg     <= 1'b0;
      hi_cnt_reg <= '0;
      lo_cnt_reg <= '0;
    end else if (idle_clear) begin
      oc_reg     <= 1'b0;
      hi_cnt_reg <= '0;
      lo_cnt_reg <= '0;
    end else if (sample_valid_reg) begin
      if (!oc_reg) begin
        lo_cnt_reg <= '0;
        if (sample_reg >= th_high) begin
          if (hi_cnt_reg + 4'd1 == DEB_CNT) begin
            oc_reg     <= 1'b1;
            hi_cnt_reg <= '0;
          end else begin
            hi_cnt_reg <= hi_cnt_reg + 4'd1;
          end
        end else begin
          hi_cnt_reg <= '0;
        end
      end else begin
        hi_cnt_reg <= '0;
        if (sample_reg <= th_low) begin
          if (lo_cnt_reg + 4'd1 == DEB_CNT) begin
            oc_reg     <= 1'b0;
            lo_cnt_reg <= '0;
          end else begin
            lo_cnt_reg <= lo_cnt_reg + 4'd1;
          end
        end else begin
          lo_cnt_reg <= '0;
        end
      end
    end
  end

`ifdef OC_SENSE_PEAK_EN
  logic [11:0] peak_reg;

  // A clear coinciding with a strobe restarts the peak from that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      peak_reg <= '0;
    else if (peak_clr)
      peak_reg <= sample_valid_reg ? sample_reg : 12'd0;
    else if (sample_valid_reg && (sample_reg > peak_reg))
      peak_reg <= sample_reg;
  end

  assign peak = peak_reg;
`endif

  assign adc_cs_n     = cs_n_reg;
  assign adc_sclk     = sclk_reg;
  assign sample       = sample_reg;
  assign sample_valid = sample_valid_reg;
  assign over_current = oc_reg;

endmodule

// File: tb/tb_oc_sense.sv
// Self-checking bench for oc_sense: serial ADC model, frame timing checks and a randomized detector reference model.
module tb_oc_sense;
  localparam int CLK_DIV  = 2;
  localparam int GAP_CYC  = 8;
  localparam int DEBOUNCE = 3;
  localparam int TCLK     = 10;
  localparam int FRAME    = 2 * CLK_DIV * 16 + 2 * CLK_DIV + 1 + GAP_CYC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] th_high, th_low;
  logic        adc_miso;
  logic        adc_cs_n, adc_sclk;
  logic [11:0] sample;
  logic        sample_valid, over_current;
`ifdef OC_SENSE_PEAK_EN
  logic        peak_clr;
  logic [11:0] peak;
`endif

  int compares   = 0;
  int mismatches = 0;

  oc_sense #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .th_high(th_high), .th_low(th_low),
    .adc_miso(adc_miso),
`ifdef OC_SENSE_PEAK_EN
    .peak_clr(peak_clr), .peak(peak),
`endif
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample(sample),
    .sample_valid(sample_valid), .over_current(over_current)
  );

  always #(TCLK / 2) clk = ~clk;

  // ADC model: one 16-bit word per chip-select frame, MSB first, new bit after each SCLK fall.
  logic [15:0] word_q[$];
  logic [11:0] exp_q[$];
  logic [15:0] cur_word;
  int          bit_idx, fall_cnt, rise_cnt, frames;
  time         fall_t, prev_fall_t;

  always @(negedge adc_cs_n) begin
    cur_word    = (word_q.size() > 0) ? word_q.pop_front() : 16'h0000;
    exp_q.push_back(cur_word[11:0]);
    bit_idx     = 0;
    fall_cnt    = 0;
    rise_cnt    = 0;
    frames      = frames + 1;
    prev_fall_t = fall_t;
    fall_t      = $time;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n == 1'b0) begin
      if (bit_idx < 16) adc_miso = cur_word[15 - bit_idx];
      bit_idx  = bit_idx + 1;
      fall_cnt = fall_cnt + 1;
    end
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n == 1'b0) rise_cnt = rise_cnt + 1;
  end

  // Reference detector: keeps the qualifying samples seen since the last output change;
  // the output flips once DEBOUNCE of them have accumulated without a break.
  bit          exp_oc;
  logic [11:0] run_hist[$];
  int          exp_peak;

  function automatic void model_step(input logic [11:0] s);
    bit qual;
    qual = exp_oc ? (int'(s) <= int'(th_low)) : (int'(s) >= int'(th_high));
    if (!qual) run_hist.delete();
    else run_hist.push_back(s);
    if (run_hist.size() == DEBOUNCE) begin
      exp_oc = ~exp_oc;
      run_hist.delete();
    end
    if (int'(s) > exp_peak) exp_peak = int'(s);
  endfunction

  task automatic get_strobe(output logic [11:0] s, output bit ok);
    ok = 1'b0;
    s  = '0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        s  = sample;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic restart();
    enable = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    word_q.delete();
    exp_q.delete();
    run_hist.delete();
    exp_oc   = 1'b0;
    exp_peak = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; th_high = 12'h800; th_low = 12'h700; adc_miso = 1'b0;
`ifdef OC_SENSE_PEAK_EN
    peak_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    compares++; if (adc_cs_n !== 1'b1) begin mismatches++; $display("FAIL reset_cs_n got %b want 1", adc_cs_n); end
    compares++; if (adc_sclk !== 1'b1) begin mismatches++; $display("FAIL reset_sclk got %b want 1", adc_sclk); end
    compares++; if (sample !== 12'h000) begin mismatches++; $display("FAIL reset_sample got %h want 000", sample); end
    compares++; if (sample_valid !== 1'b0) begin mismatches++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    compares++; if (over_current !== 1'b0) begin mismatches++; $display("FAIL reset_oc got %b want 0", over_current); end
    rst_n = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_frame();
    logic [11:0] s;
    bit ok;
    int t;
    restart();
    word_q.push_back(16'h0ABC);
    word_q.push_back(16'h0ABC);
    enable = 1'b1;
    t = 0;
    while (adc_cs_n !== 1'b0 && t < 4 * FRAME) begin @(negedge clk); t++; end
    while (adc_cs_n !== 1'b1 && t < 8 * FRAME) begin @(negedge clk); t++; end
    compares++; if (t >= 8 * FRAME) begin mismatches++; $display("FAIL frame_timeout got %0d cycles want <%0d", t, 8 * FRAME); end
    compares++; if (fall_cnt != 16) begin mismatches++; $display("FAIL frame_sclk_falls got %0d want 16", fall_cnt); end
    compares++; if (rise_cnt != 16) begin mismatches++; $display("FAIL frame_sclk_rises got %0d want 16", rise_cnt); end
    get_strobe(s, ok);
    compares++; if (!ok || s !== 12'hABC) begin mismatches++; $display("FAIL frame_sample got %h ok=%0d want abc", s, ok); end
    @(negedge clk);
    compares++; if (sample_valid !== 1'b0) begin mismatches++; $display("FAIL frame_strobe_width got %b want 0", sample_valid); end
    t = 0;
    while (adc_cs_n !== 1'b0 && t < 4 * FRAME) begin @(negedge clk); t++; end
    compares++; if ((fall_t - prev_fall_t) != FRAME * TCLK) begin
      mismatches++; $display("FAIL frame_period got %0d want %0d", (fall_t - prev_fall_t) / TCLK, FRAME);
    end
    $display("frame: sample=%h period=%0d clk", s, (fall_t - prev_fall_t) / TCLK);
  endtask

  task automatic test_set_debounce();
    logic [11:0] s, e;
    bit ok;
    restart();
    th_high = 12'h800; th_low = 12'h700;
    for (int i = 0; i < 3; i++) word_q.push_back(16'h0900);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_strobe(s, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      compares++; if (!ok || s !== e) begin mismatches++; $display("FAIL set_sample[%0d] got %h want %h", i, s, e); end
      model_step(e);
      @(negedge clk);
      compares++; if (over_current !== exp_oc) begin mismatches++; $display("FAIL set_oc[%0d] got %b want %b", i, over_current, exp_oc); end
      $display("set: sample=%h oc=%b", s, over_current);
    end
    compares++; if (over_current !== 1'b1) begin mismatches++; $display("FAIL set_final got %b want 1", over_current); end
  endtask

  task automatic test_dip();
    logic [11:0] words[6] = '{12'h900, 12'h900, 12'h100, 12'h900, 12'h900, 12'h900};
    logic [11:0] s, e;
    bit ok;
    restart();
    th_high = 12'h800; th_low = 12'h700;
    foreach (words[i]) word_q.push_back({4'h5, words[i]});
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      get_strobe(s, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      compares++; if (!ok || s !== e) begin mismatches++; $display("FAIL dip_sample[%0d] got %h want %h", i, s, e); end
      model_step(e);
      @(negedge clk);
      compares++; if (over_current !== exp_oc) begin mismatches++; $display("FAIL dip_oc[%0d] got %b want %b", i, over_current, exp_oc); end
      $display("dip: sample=%h oc=%b", s, over_current);
    end
  endtask

  task automatic test_hysteresis();
    logic [11:0] s, e;
    bit ok;
    restart();
    th_high = 12'h800; th_low = 12'h700;
    for (int i = 0; i < 3; i++) word_q.push_back(16'h0900);
    for (int i = 0; i < 5; i++) word_q.push_back(16'h0780);
    for (int i = 0; i < 3; i++) word_q.push_back(16'h0600);
    enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      get_strobe(s, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      compares++; if (!ok || s !== e) begin mismatches++; $display("FAIL hyst_sample[%0d] got %h want %h", i, s, e); end
      model_step(e);
      @(negedge clk);
      compares++; if (over_current !== exp_oc) begin mismatches++; $display("FAIL hyst_oc[%0d] got %b want %b", i, over_current, exp_oc); end
      $display("hyst: sample=%h oc=%b", s, over_current);
    end
  endtask

  task automatic test_boundaries();
    logic [11:0] words[11] = '{12'h000, 12'h000, 12'h000, 12'hFFE, 12'hFFE, 12'hFFE,
                               12'hFFE, 12'hFFE, 12'hFFF, 12'hFFF, 12'hFFF};
    logic [11:0] s, e;
    bit ok;
    restart();
    th_high = 12'h000; th_low = 12'h000;
    foreach (words[i]) word_q.push_back({4'hF, words[i]});
    enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      get_strobe(s, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      compares++; if (!ok || s !== e) begin mismatches++; $display("FAIL bound_sample[%0d] got %h want %h", i, s, e); end
      model_step(e);
      @(negedge clk);
      compares++; if (over_current !== exp_oc) begin mismatches++; $display("FAIL bound_oc[%0d] got %b want %b", i, over_current, exp_oc); end
      $display("bound: th_high=%h th_low=%h sample=%h oc=%b", th_high, th_low, s, over_current);
      if (i == 2) begin th_high = 12'hFFF; th_low = 12'hFFF; end
    end
  endtask

  task automatic test_enable_drop();
    logic [11:0] s, e;
    bit ok;
    int t, frames_before;
    restart();
    th_high = 12'h800; th_low = 12'h700;
    for (int i = 0; i < 3; i++) word_q.push_back(16'h0900);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      get_strobe(s, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      model_step(e);
    end
    t = 0;
    while (adc_cs_n !== 1'b0 && t < 4 * FRAME) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    enable = 1'b0;
    frames_before = frames;
    get_strobe(s, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
    compares++; if (!ok || s !== e) begin mismatches++; $display("FAIL drop_sample got %h ok=%0d want %h", s, ok, e); end
    model_step(e);
    @(negedge clk);
    compares++; if (over_current !== exp_oc) begin mismatches++; $display("FAIL drop_oc_set got %b want %b", over_current, exp_oc); end
    repeat (2 * FRAME) @(negedge clk);
    compares++; if (adc_cs_n !== 1'b1) begin mismatches++; $display("FAIL drop_cs_n got %b want 1", adc_cs_n); end
    compares++; if (frames != frames_before) begin mismatches++; $display("FAIL drop_frames got %0d want %0d", frames, frames_before); end
    compares++; if (over_current !== 1'b0) begin mismatches++; $display("FAIL drop_oc_idle got %b want 0", over_current); end
    $display("drop: sample=%h idle oc=%b cs_n=%b", s, over_current, adc_cs_n);
  endtask

  task automatic test_reset_mid();
    int t;
    word_q.push_back(16'h0ABC);
    enable = 1'b1;
    t = 0;
    while (adc_cs_n !== 1'b0 && t < 4 * FRAME) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compares++; if (adc_cs_n !== 1'b1) begin mismatches++; $display("FAIL rstmid_cs_n got %b want 1", adc_cs_n); end
    compares++; if (adc_sclk !== 1'b1) begin mismatches++; $display("FAIL rstmid_sclk got %b want 1", adc_sclk); end
    compares++; if (sample !== 12'h000) begin mismatches++; $display("FAIL rstmid_sample got %h want 000", sample); end
    compares++; if (sample_valid !== 1'b0) begin mismatches++; $display("FAIL rstmid_valid got %b want 0", sample_valid); end
    compares++; if (over_current !== 1'b0) begin mismatches++; $display("FAIL rstmid_oc got %b want 0", over_current); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-frame: outputs checked");
  endtask

  task automatic test_random();
    logic [11:0] s, e, v;
    bit ok;
    int r;
    restart();
    th_high = 12'($urandom_range(12'h400, 12'hC00));
    th_low  = th_high - 12'($urandom_range(0, 12'h300));
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 4);
      if (r <= 1)      v = 12'($urandom_range(int'(th_high), 4095));
      else if (r == 2) v = 12'($urandom_range(int'(th_low), int'(th_high)));
      else             v = 12'($urandom_range(0, int'(th_low)));
      word_q.push_back({4'($urandom_range(0, 15)), v});
    end
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      get_strobe(s, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      compares++; if (!ok || s !== e) begin mismatches++; $display("FAIL rand_sample[%0d] got %h want %h", i, s, e); end
      model_step(e);
      @(negedge clk);
      compares++; if (over_current !== exp_oc) begin mismatches++; $display("FAIL rand_oc[%0d] got %b want %b", i, over_current, exp_oc); end
      $display("rand: th=%h/%h sample=%h oc=%b", th_high, th_low, s, over_current);
    end
  endtask

`ifdef OC_SENSE_PEAK_EN
  task automatic test_peak();
    logic [11:0] s, e;
    bit ok;
    restart();
    @(negedge clk); peak_clr = 1'b1;
    @(negedge clk); peak_clr = 1'b0;
    compares++; if (peak !== 12'h000) begin mismatches++; $display("FAIL peak_clr got %h want 000", peak); end
    word_q.push_back(16'h0300); word_q.push_back(16'h0900);
    word_q.push_back(16'h0500); word_q.push_back(16'h0200);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_strobe(s, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      model_step(e);
      @(negedge clk);
      compares++; if (peak !== 12'(exp_peak)) begin mismatches++; $display("FAIL peak_track[%0d] got %h want %h", i, peak, 12'(exp_peak)); end
      $display("peak: sample=%h peak=%h", s, peak);
    end
    get_strobe(s, ok);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    compares++; if (peak !== 12'h200) begin mismatches++; $display("FAIL peak_coincide got %h want 200", peak); end
    $display("peak: clear with sample=%h peak=%h", s, peak);
  endtask
`endif

  initial begin
    frames = 0; fall_t = 0; prev_fall_t = 0; exp_oc = 1'b0; exp_peak = 0;
    test_reset();
    test_frame();
    test_set_debounce();
    test_dip();
    test_hysteresis();
    test_boundaries();
    test_enable_drop();
    test_reset_mid();
    test_random();
`ifdef OC_SENSE_PEAK_EN
    test_peak();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

  initial begin
    #(90000 * TCLK);
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
